// File: rtl/fetch_pkg.sv
// Shared defaults and types for the buffered fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 64;
  localparam int FETCH_INST_W = 32;
  localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'hD8;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response and decode handshake bundle for fetch.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INST_W = FETCH_INST_W
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid_D;
  logic              inst_ready_D;
  logic [INST_W-1:0] inst_D;
  logic [ADDR_W-1:0] pc_D;

  // Fetch side
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid_D, inst_D, pc_D,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready_D
  );

  // Memory / decode side
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid_D, inst_D, pc_D,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready_D
  );

endinterface

// File: rtl/fetch_queue.sv
// Three-pointer fetch buffer: alloc reserves a slot at request time, fill writes
// the returning instruction in order, rd pops to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INST_W = FETCH_INST_W,
  parameter int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill_en,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              pop_en,
  output logic [PTR_W-1:0]  occupancy,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  alloc_q, alloc_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    rd_d    = rd_q;
    if (flush) begin
      alloc_d = '0;
      fill_d  = '0;
      rd_d    = '0;
    end else begin
      if (alloc_en) alloc_d = alloc_q + PTR_W'(1);
      if (fill_en)  fill_d  = fill_q + PTR_W'(1);
      if (pop_en)   rd_d    = rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_q <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
    end
  end

  // Payload storage carries no reset; pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (alloc_en && !flush) pc_mem[alloc_q[IDX_W-1:0]] <= alloc_pc;
    if (fill_en && !flush)  inst_mem[fill_q[IDX_W-1:0]] <= fill_inst;
  end

  assign occupancy  = alloc_q - rd_q;
  assign head_valid = (fill_q != rd_q);
  assign head_pc    = pc_mem[rd_q[IDX_W-1:0]];
  assign head_inst  = inst_mem[rd_q[IDX_W-1:0]];

endmodule

// File: rtl/fetch_buffered.sv
// Fetch stage with PC/redirect control, valid/ready imem port with in-order
// variable-latency responses, and a DEPTH-entry queue decoupling decode.
module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = FETCH_ADDR_W,
  parameter int                INST_W     = FETCH_INST_W,
  parameter int                DEPTH      = 4,
  parameter int                INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EProc_F,
  input  logic              PCSrc_F,
  input  logic [ADDR_W-1:0] PCBranch_F,
  output logic [ADDR_W-1:0] NextPC_F,
  fetch_if.master           bus
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  // Stale responses from repeated redirects can outnumber the queue depth.
  localparam int CNT_W = PTR_W + 2;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              redirect;
  logic              req_valid, req_fire;
  logic              inst_valid, pop_fire;
  logic              dropping, rsp_keep;
  logic [ADDR_W-1:0] pc_plus, next_pc;
  logic [PTR_W-1:0]  occupancy;
  logic              head_valid;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;

  always_comb begin
    redirect   = EProc_F | PCSrc_F;
    pc_plus    = pc_q + ADDR_W'(INST_BYTES);
    req_valid  = !reset && !redirect && (occupancy < PTR_W'(DEPTH));
    req_fire   = req_valid && bus.imem_req_ready;
    inst_valid = !reset && !redirect && head_valid;
    pop_fire   = inst_valid && bus.inst_ready_D;
    dropping   = (drop_cnt_q != '0);
    rsp_keep   = bus.imem_rsp_valid && !dropping && !redirect;

    next_pc = pc_q;
    if (redirect)      next_pc = EProc_F ? EXC_VECTOR : PCBranch_F;
    else if (req_fire) next_pc = pc_plus;
    pc_d = reset ? RESET_PC : next_pc;

    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);

    // Everything still in flight at a redirect is stale, minus this cycle's arrival.
    drop_cnt_d = drop_cnt_q;
    if (redirect)
      drop_cnt_d = outstanding_q - CNT_W'(bus.imem_rsp_valid);
    else if (bus.imem_rsp_valid && dropping)
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .PTR_W  (PTR_W)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .alloc_en   (req_fire),
    .alloc_pc   (pc_q),
    .fill_en    (rsp_keep),
    .fill_inst  (bus.imem_rsp_data),
    .pop_en     (pop_fire),
    .occupancy  (occupancy),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst)
  );

  assign NextPC_F           = pc_d;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid_D   = inst_valid;
  assign bus.inst_D         = head_inst;
  assign bus.pc_D           = head_pc;

endmodule
